// File: rtl/gpio_pad_ctrl.sv
// Per-pad config/mux stage: serial config chain, break-before-make commit FSM, pad output muxing.
// Optional GPIO_PAD_IN_SYNC_EN adds a 2-flop synchronizer on the pad input return path.
module gpio_pad_ctrl #(
  parameter logic [8:0]  CFG_DEFAULT = 9'h005,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       serial_shift,
  input  logic       serial_data_in,
  output logic       serial_data_out,
  input  logic       serial_load,
  input  logic       mgmt_gpio_out,
  input  logic       mgmt_gpio_oe,
  output logic       mgmt_gpio_in,
  input  logic       user_gpio_out,
  input  logic       user_gpio_oe,
  output logic       user_gpio_in,
  output logic       pad_a,
  output logic       pad_oe,
  output logic       pad_ie,
  output logic       pad_cs,
  output logic       pad_sl,
  output logic       pad_pu,
  output logic       pad_pd,
  output logic [1:0] pad_drv,
  input  logic       pad_y,
  output logic [8:0] cfg_active
);

  typedef enum logic {RUN, DEAD} state_t;

  localparam logic [3:0] DEAD_LOAD = DEAD_CYCLES[3:0];

  logic [8:0] shadow_q, shadow_d;
  logic [8:0] pending_q, pending_d;
  logic [8:0] active_q, active_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic       disruptive;
  logic       mgmt_en;
  logic       pad_in_s;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      shadow_q  <= '0;
      pending_q <= '0;
      active_q  <= CFG_DEFAULT;
      cnt_q     <= '0;
      state_q   <= RUN;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  // Ownership or drive-strength changes must not glitch the pad, so they go through DEAD.
  assign disruptive = (shadow_q[1:0] != active_q[1:0]) || (shadow_q[8:7] != active_q[8:7]);

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    if (serial_shift) begin
      shadow_d = {shadow_q[7:0], serial_data_in};
    end
    case (state_q)
      RUN: begin
        if (serial_load) begin
          pending_d = shadow_q;
          if (disruptive && (DEAD_LOAD != 4'd0)) begin
            state_d = DEAD;
            cnt_d   = DEAD_LOAD;
          end else begin
            active_d = shadow_q;
          end
        end
      end
      DEAD: begin
        // A new load while dead restarts the full dead time with the newest config.
        if (serial_load) begin
          pending_d = shadow_q;
          cnt_d     = DEAD_LOAD;
        end else if (cnt_q == 4'd1) begin
          active_d = pending_q;
          cnt_d    = 4'd0;
          state_d  = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

`ifdef GPIO_PAD_IN_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], pad_y & active_q[2]};
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pad_in_s = sync_q[1];
`else
  assign pad_in_s = pad_y & active_q[2];
`endif

  assign mgmt_en         = active_q[0];
  assign serial_data_out = shadow_q[8];
  assign cfg_active      = active_q;

  assign pad_a   = mgmt_en ? mgmt_gpio_out : user_gpio_out;
  assign pad_oe  = (state_q == RUN) & ~active_q[1] & (mgmt_en ? mgmt_gpio_oe : user_gpio_oe);
  assign pad_ie  = active_q[2];
  assign pad_cs  = active_q[3];
  assign pad_sl  = active_q[4];
  assign pad_pu  = active_q[5];
  assign pad_pd  = active_q[6];
  assign pad_drv = active_q[8:7];

  assign mgmt_gpio_in = pad_in_s;
  assign user_gpio_in = mgmt_en ? 1'b0 : pad_in_s;

endmodule
